// File: rtl/gb_bus_pkg.sv
// Shared types for the 8-bit tri-state data bus and the RAM responder FSM.
package gb_bus_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        READ
    } resp_state_t;

endpackage

// File: rtl/resp_mem_array.sv
// DEPTH x data_t storage: synchronous write port, registered synchronous read port.
module resp_mem_array
    import gb_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  data_t         wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output data_t         rdata_o
);

    data_t mem_q [DEPTH];
    data_t rdata_q;

    // Storage itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 8'h00;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[rd_addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mapped_ram_responder.sv
// Memory-mapped RAM target on the shared tri-state bus with one-cycle read latency.
// Optional post-reset storage sweep enabled by defining MEM_CLEAR_EN.
module mapped_ram_responder
    import gb_bus_pkg::*;
#(
    parameter addr_t       BASE_ADDR = 16'hFF80,
    parameter int unsigned DEPTH     = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  addr_t      address,
    inout  wire [7:0]  databus,
    input  logic       RE,
    input  logic       WE,
    output logic       hit,
    output logic       ready,
    output logic       collision
);

    localparam int unsigned AW = $clog2(DEPTH);

`ifdef MEM_CLEAR_EN
    localparam resp_state_t RESET_STATE = CLEAR;
`else
    localparam resp_state_t RESET_STATE = IDLE;
`endif

    resp_state_t   state_q, state_d;
    logic          ready_q, ready_d;
    logic          collision_q, collision_d;
    logic          wr_en_c, rd_en_c, coll_c, drive_c;
    logic [AW-1:0] offset_c, wr_addr_c;
    data_t         wr_data_c, rdata_c;
`ifdef MEM_CLEAR_EN
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
`endif

    assign offset_c = address[AW-1:0];
    assign hit      = (address[15:AW] == BASE_ADDR[15:AW]);
    assign coll_c   = hit && RE && WE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RESET_STATE;
            ready_q     <= 1'b0;
            collision_q <= 1'b0;
`ifdef MEM_CLEAR_EN
            clr_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            collision_q <= collision_d;
`ifdef MEM_CLEAR_EN
            clr_cnt_q   <= clr_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        collision_d = 1'b0;
        wr_en_c     = 1'b0;
        wr_addr_c   = offset_c;
        wr_data_c   = databus;
        rd_en_c     = 1'b0;
`ifdef MEM_CLEAR_EN
        clr_cnt_d   = clr_cnt_q;
`endif
        case (state_q)
`ifdef MEM_CLEAR_EN
            CLEAR: begin
                wr_en_c   = 1'b1;
                wr_addr_c = clr_cnt_q;
                wr_data_c = 8'h00;
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
`endif
            IDLE: begin
                if (coll_c) begin
                    collision_d = 1'b1;
                end else if (hit && ready_q && WE) begin
                    wr_en_c = 1'b1;
                end else if (hit && ready_q && RE) begin
                    rd_en_c = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                // Any change of strobe or window drops back to IDLE without an access.
                if (coll_c) begin
                    collision_d = 1'b1;
                    state_d     = IDLE;
                end else if (hit && RE && !WE) begin
                    rd_en_c = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d != CLEAR);
    end

    resp_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en_c),
        .wr_addr_i (wr_addr_c),
        .wr_data_i (wr_data_c),
        .rd_en_i   (rd_en_c),
        .rd_addr_i (offset_c),
        .rdata_o   (rdata_c)
    );

    // Combinational gating so the bus is released the same cycle RE drops.
    assign drive_c   = (state_q == READ) && RE && hit && !WE;
    assign databus   = drive_c ? rdata_c : 8'bz;
    assign ready     = ready_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_mapped_ram_responder.sv
// Directed self-checking bench for mapped_ram_responder; a released bus reads 8'hFF via pullups.
module tb_mapped_ram_responder;

    localparam logic [7:0] BUS_Z = 8'hFF;
`ifdef MEM_CLEAR_EN
    localparam int RDY_LOW  = 128;
    localparam logic [7:0] FFFF_AFTER_RST = 8'h00;
`else
    localparam int RDY_LOW  = 1;
    localparam logic [7:0] FFFF_AFTER_RST = 8'h5E;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] address;
    logic        RE, WE;
    logic        drv_en;
    logic [7:0]  drv;
    wire  [7:0]  databus;
    logic        hit, ready, collision;
    int          n_total = 0;
    int          n_bad   = 0;

    always #5 clk = ~clk;

    assign databus = drv_en ? drv : 8'bz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (databus[i]);
    end

    mapped_ram_responder dut (
        .clk       (clk),
        .rst       (rst),
        .address   (address),
        .databus   (databus),
        .RE        (RE),
        .WE        (WE),
        .hit       (hit),
        .ready     (ready),
        .collision (collision)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        address = a; drv = d; drv_en = 1'b1; WE = 1'b1; RE = 1'b0;
        tick();
        WE = 1'b0; drv_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
        address = a; RE = 1'b1;
        tick();
        #2 check_val(tag, 32'(databus), 32'(exp));
        RE = 1'b0;
        tick();
    endtask

    // Counts edges after rst release until ready rises, bounded.
    task automatic wait_ready(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!ready && n < 400);
        check_val(tag, 32'(n), 32'(RDY_LOW));
    endtask

    initial begin
        rst = 1'b1; address = 16'h0000; RE = 1'b0; WE = 1'b0; drv_en = 1'b0; drv = 8'h00;
        tick(); tick();
        #2;
        check_val("rst_ready", 32'(ready), 32'd0);
        check_val("rst_coll", 32'(collision), 32'd0);
        check_val("rst_bus", 32'(databus), 32'(BUS_Z));
        rst = 1'b0;
        wait_ready("rdy_low_init");

        // Basic write then read, same-cycle release on RE drop.
        wr(16'hFF80, 8'hA5);
        address = 16'hFF80; RE = 1'b1;
        #2;
        check_val("hit_ff80", 32'(hit), 32'd1);
        check_val("bus_pre_read", 32'(databus), 32'(BUS_Z));
        tick();
        #2 check_val("rd_a5", 32'(databus), 32'h000000A5);
        RE = 1'b0;
        #2 check_val("release_re", 32'(databus), 32'(BUS_Z));
        tick();

        // Miss accesses: wrap-alias FF7F must not touch FFFF.
        wr(16'hFFFF, 8'h5E);
        address = 16'hFF7F; drv = 8'h3C; drv_en = 1'b1; WE = 1'b1;
        #2 check_val("hit_ff7f", 32'(hit), 32'd0);
        tick();
        WE = 1'b0; drv_en = 1'b0;
        address = 16'h0000; RE = 1'b1;
        #2 check_val("hit_0000", 32'(hit), 32'd0);
        tick();
        #2 check_val("miss_bus0", 32'(databus), 32'(BUS_Z));
        tick();
        #2 check_val("miss_bus1", 32'(databus), 32'(BUS_Z));
        RE = 1'b0;
        tick();
        rd("rd_ffff_kept", 16'hFFFF, 8'h5E);
        rd("rd_ff80_kept", 16'hFF80, 8'hA5);

        // Streaming read while the address steps.
        wr(16'hFF81, 8'h11);
        wr(16'hFF82, 8'h22);
        wr(16'hFF83, 8'h33);
        address = 16'hFF81; RE = 1'b1;
        tick();
        #2 check_val("stream_11", 32'(databus), 32'h11);
        address = 16'hFF82;
        tick();
        #2 check_val("stream_22", 32'(databus), 32'h22);
        address = 16'hFF83;
        tick();
        #2 check_val("stream_33", 32'(databus), 32'h33);
        address = 16'hFF7F;
        #2 check_val("release_miss", 32'(databus), 32'(BUS_Z));
        RE = 1'b0;
        tick();

        // Collision: single-cycle pulse, no write.
        wr(16'hFF90, 8'h44);
        address = 16'hFF90; RE = 1'b1; WE = 1'b1; drv = 8'h77; drv_en = 1'b1;
        #2 check_val("coll_before", 32'(collision), 32'd0);
        tick();
        #2;
        check_val("coll_pulse", 32'(collision), 32'd1);
        check_val("coll_bus", 32'(databus), 32'h77);
        RE = 1'b0; WE = 1'b0; drv_en = 1'b0;
        tick();
        #2 check_val("coll_end", 32'(collision), 32'd0);
        rd("rd_ff90_kept", 16'hFF90, 8'h44);

        // Reset in the middle of a read.
        address = 16'hFFFF; RE = 1'b1;
        tick();
        #2 check_val("pre_rst_rd", 32'(databus), 32'h5E);
        rst = 1'b1;
        tick();
        #2;
        check_val("rst_mid_bus", 32'(databus), 32'(BUS_Z));
        check_val("rst_mid_ready", 32'(ready), 32'd0);
        WE = 1'b1; drv = 8'h99; drv_en = 1'b1;
        tick();
        #2 check_val("rst_mid_coll", 32'(collision), 32'd0);
        WE = 1'b0; drv_en = 1'b0; rst = 1'b0;
        #2 check_val("rst_rel_bus", 32'(databus), 32'(BUS_Z));
        wait_ready("rdy_low_mid");
        #2 check_val("rdy_edge_bus", 32'(databus), 32'(BUS_Z));
        tick();
        #2 check_val("post_rst_rd", 32'(databus), 32'(FFFF_AFTER_RST));
        RE = 1'b0;
        tick();

`ifdef MEM_CLEAR_EN
        wr(16'hFF80, 8'hFF);
        wr(16'hFFFF, 8'hFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready("clr_low");
        rd("clr_ff80", 16'hFF80, 8'h00);
        rd("clr_ffff", 16'hFFFF, 8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (50) tick();
        #2 check_val("clr_mid_ready", 32'(ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready("clr_restart");
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
